// File: rtl/dataisland_scheduler_if.sv
// Packet request/grant and shared byte-read port between the
// data island scheduler and its packet sources.
interface dataisland_scheduler_if;
  logic [3:0] iReq;
  logic [3:0] oGrant;
  logic [1:0] oRdSel;
  logic [4:0] oRdAddr;
  logic [7:0] iRdData;

  modport master (
    input  iReq,
    input  iRdData,
    output oGrant,
    output oRdSel,
    output oRdAddr
  );

  modport slave (
    output iReq,
    output iRdData,
    input  oGrant,
    input  oRdSel,
    input  oRdAddr
  );
endinterface

// File: rtl/dataisland_scheduler.sv
// Data island scheduler: per-line packet fetch, BCH ECC and
// TERC4 nibble serialisation for the blue/green/red encoders.
module dataisland_scheduler #(
  parameter int ISLAND_X = 751,
  parameter int LOAD_X   = 600
) (
  input  logic                          clkin,
  input  logic                          rstin_n,
  input  logic [11:0]                   counterX,
  input  logic                          iHsync,
  input  logic                          iVsync,
  dataisland_scheduler_if.master        bus,
  output logic [3:0]                    oDataCh0,
  output logic [3:0]                    oDataCh1,
  output logic [3:0]                    oDataCh2
);
  localparam logic [11:0] LX = 12'(LOAD_X);
  localparam logic [11:0] IX = 12'(ISLAND_X);

  typedef enum logic [2:0] {
    IDLE, ARB, LOAD, WAIT, SEND
  } state_t;

  state_t      state;
  logic        slot;
  logic [1:0]  ptr;
  logic [4:0]  cnt;
  logic [1:0]  sub_k;
  logic [2:0]  sub_j;
  logic [1:0]  vld;
  logic [5:0]  pix;
  logic        hs_d;
  logic        vs_d;

  logic [23:0] hdr  [2];
  logic [7:0]  hecc [2];
  logic [55:0] sub  [2][4];
  logic [7:0]  secc [2][4];

  logic [4:0]  bidx;
  assign bidx = cnt - 5'd1;

  function automatic logic [7:0] ecc_byte(
    input logic [7:0] ecc,
    input logic [7:0] b
  );
    logic [7:0] e;
    logic       fb;
    e = ecc;
    for (int n = 0; n < 8; n++) begin
      fb = b[n] ^ e[0];
      e  = {1'b0, e[7:1]} ^ (fb ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  // round-robin pick starting at ptr
  logic       any_req;
  logic [1:0] pick;
  logic [1:0] idx;
  always_comb begin
    any_req = 1'b0;
    pick    = ptr;
    idx     = '0;
    for (int o = 3; o >= 0; o--) begin
      idx = ptr + 2'(o);
      if (bus.iReq[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  logic        pk;
  logic [4:0]  pi;
  logic [31:0] hword;
  logic [63:0] sw;
  logic [3:0]  d0;
  logic [3:0]  d1;
  logic [3:0]  d2;
  always_comb begin
    pk    = pix[5];
    pi    = pix[4:0];
    hword = vld[pk] ? {hecc[pk], hdr[pk]} : 32'h0;
    d1    = '0;
    d2    = '0;
    sw    = '0;
    for (int k = 0; k < 4; k++) begin
      sw    = vld[pk] ? {secc[pk][k], sub[pk][k]} : 64'h0;
      d1[k] = sw[{pi, 1'b0}];
      d2[k] = sw[{pi, 1'b1}];
    end
    d0 = {pi != 5'd0, hword[pi], vs_d, hs_d};
  end

  always_ff @(posedge clkin) begin
    if (!rstin_n) begin
      state       <= IDLE;
      slot        <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
      sub_k       <= '0;
      sub_j       <= '0;
      vld         <= '0;
      pix         <= '0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      bus.oGrant  <= '0;
      bus.oRdSel  <= '0;
      bus.oRdAddr <= '0;
      oDataCh0    <= '0;
      oDataCh1    <= '0;
      oDataCh2    <= '0;
    end else begin
      hs_d       <= iHsync;
      vs_d       <= iVsync;
      bus.oGrant <= '0;
      oDataCh0   <= {2'b00, vs_d, hs_d};
      oDataCh1   <= '0;
      oDataCh2   <= '0;
      unique case (state)
        IDLE: begin
          if (counterX == LX) begin
            state <= ARB;
            slot  <= 1'b0;
          end
        end
        ARB: begin
          if (counterX == IX) begin
            state <= SEND;
            pix   <= '0;
          end else if (!any_req) begin
            state <= WAIT;
          end else begin
            bus.oRdSel  <= pick;
            bus.oRdAddr <= '0;
            cnt         <= '0;
            sub_k       <= '0;
            sub_j       <= '0;
            hecc[slot]  <= '0;
            for (int k = 0; k < 4; k++) secc[slot][k] <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          // the window start wins over an unfinished load
          if (counterX == IX) begin
            state       <= SEND;
            pix         <= '0;
            bus.oRdAddr <= '0;
          end else begin
            cnt <= cnt + 5'd1;
            if (cnt < 5'd30) bus.oRdAddr <= cnt + 5'd1;
            if (cnt != 5'd0) begin
              if (bidx < 5'd3) begin
                hdr[slot][{bidx[1:0], 3'b000} +: 8] <= bus.iRdData;
                hecc[slot] <= ecc_byte(hecc[slot], bus.iRdData);
              end else begin
                sub[slot][sub_k][{sub_j, 3'b000} +: 8] <= bus.iRdData;
                secc[slot][sub_k] <=
                  ecc_byte(secc[slot][sub_k], bus.iRdData);
                if (sub_j == 3'd6) begin
                  sub_j <= '0;
                  sub_k <= sub_k + 2'd1;
                end else begin
                  sub_j <= sub_j + 3'd1;
                end
              end
            end
            if (cnt == 5'd31) begin
              bus.oGrant[bus.oRdSel] <= 1'b1;
              vld[slot]   <= 1'b1;
              ptr         <= bus.oRdSel + 2'd1;
              bus.oRdAddr <= '0;
              if (slot) begin
                state <= WAIT;
              end else begin
                state <= ARB;
                slot  <= 1'b1;
              end
            end
          end
        end
        WAIT: begin
          if (counterX == IX) begin
            state <= SEND;
            pix   <= '0;
          end
        end
        SEND: begin
          oDataCh0 <= d0;
          oDataCh1 <= d1;
          oDataCh2 <= d2;
          pix      <= pix + 6'd1;
          if (pix == 6'd63) begin
            vld   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
